pc_fetch: RTL and testbench

//  Fetch stage upstream of the synchronous instruction memory (word-addressed, read at posedge clk).
//  - Owns the program counter and drives the memory address.
//  - Re-associates each returned instruction with its PC and marks it valid; wrong-path words after redirects are squashed.
//  - Holds the fetched word stable across decode stalls and presents the IF/ID pair to the decoder.

---
 rtl/pipe_pkg.sv | 18 +
 rtl/pc_next_calc.sv | 22 ++
 rtl/pc_fetch.sv | 148 ++++++++++++++
 tb/tb_pc_fetch.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared fetch-pipe types: FSM state encoding, word width and the IF/ID bundle.
package pipe_pkg;

    localparam int WORD_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [WORD_W-1:0] pc;
        logic [WORD_W-1:0] inst;
        logic              valid;
    } if_id_t;

endpackage

// File: rtl/pc_next_calc.sv
// Combinational next-PC candidates: wrapped increment, masked redirect target and
// out-of-range target detection for a power-of-two instruction memory.
module pc_next_calc
    import pipe_pkg::*;
#(
    parameter int IMEM_DEPTH = 128
) (
    input  logic [WORD_W-1:0] pc,
    input  logic [WORD_W-1:0] target,
    output logic [WORD_W-1:0] pc_inc,
    output logic [WORD_W-1:0] target_masked,
    output logic              target_oob
);

    localparam logic [WORD_W-1:0] DEPTH = WORD_W'(IMEM_DEPTH);
    localparam logic [WORD_W-1:0] MASK  = DEPTH - WORD_W'(1);

    assign pc_inc        = (pc + WORD_W'(1)) & MASK;
    assign target_masked = target & MASK;
    assign target_oob    = (target >= DEPTH);

endmodule

// File: rtl/pc_fetch.sv
// Fetch stage: owns the PC, pairs returned memory words with their PC and holds them across stalls.
// Optional performance counters are built when FETCH_PERF_CNT_EN is defined.
module pc_fetch
    import pipe_pkg::*;
#(
    parameter int                IMEM_DEPTH = 128,
    parameter logic [WORD_W-1:0] RESET_PC   = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic              halt_i,
    input  logic              stall_i,
    input  logic              branch_taken_i,
    input  logic [WORD_W-1:0] branch_target_i,
    input  logic              flush_i,
    output logic [WORD_W-1:0] pc_o,
    input  logic [WORD_W-1:0] inst_i,
    output logic [WORD_W-1:0] if_pc_o,
    output logic [WORD_W-1:0] if_inst_o,
    output logic              if_valid_o,
    output logic              addr_err_o
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]       fetch_cnt_o,
    output logic [31:0]       redirect_cnt_o
`endif
);

    localparam logic [1:0] ST_IDLE = 2'(IDLE);
    localparam logic [1:0] ST_RUN  = 2'(RUN);
    localparam logic [1:0] ST_HALT = 2'(HALT);

    logic [1:0]        state_q;
    logic [WORD_W-1:0] pc_p0;
    logic [WORD_W-1:0] if_pc_p1;
    logic [WORD_W-1:0] inst_hold_p1;
    logic              vld_p1;
    logic              hold_p1;
    logic              addr_err_q;

    logic              run;
    logic              redirect;
    logic              advance;
    logic              capture;
    logic [WORD_W-1:0] pc_inc;
    logic [WORD_W-1:0] target_masked;
    logic              target_oob;
    if_id_t            if_id_p1;

    assign run      = (state_q == ST_RUN);
    assign redirect = run & branch_taken_i;
    assign advance  = run & ~branch_taken_i & ~halt_i & ~stall_i;
    // First stalled edge of a live word: snapshot it before memory moves on to pc_o.
    assign capture  = run & ~branch_taken_i & ~halt_i & stall_i & ~flush_i & ~hold_p1;

    pc_next_calc #(
        .IMEM_DEPTH(IMEM_DEPTH)
    ) u_next (
        .pc           (pc_p0),
        .target       (branch_target_i),
        .pc_inc       (pc_inc),
        .target_masked(target_masked),
        .target_oob   (target_oob)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: if (start_i) state_q <= ST_RUN;
                ST_RUN:  if (halt_i)  state_q <= ST_HALT;
                ST_HALT: if (start_i) state_q <= ST_RUN;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Stage p0 -> p1: PC advance/redirect and IF/ID valid tracking
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_p0      <= RESET_PC;
            if_pc_p1   <= '0;
            vld_p1     <= 1'b0;
            hold_p1    <= 1'b0;
            addr_err_q <= 1'b0;
        end else if (!run) begin
            vld_p1  <= 1'b0;
            hold_p1 <= 1'b0;
        end else if (redirect) begin
            pc_p0   <= target_masked;
            vld_p1  <= 1'b0;
            hold_p1 <= 1'b0;
            if (target_oob) addr_err_q <= 1'b1;
        end else if (halt_i) begin
            vld_p1  <= 1'b0;
            hold_p1 <= 1'b0;
        end else if (stall_i) begin
            if (flush_i) begin
                vld_p1  <= 1'b0;
                hold_p1 <= 1'b0;
            end else begin
                hold_p1 <= 1'b1;
            end
        end else begin
            pc_p0    <= pc_inc;
            if_pc_p1 <= pc_p0;
            vld_p1   <= ~flush_i;
            hold_p1  <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (capture) inst_hold_p1 <= inst_i;
    end

    assign if_id_p1 = '{pc: if_pc_p1, inst: (hold_p1 ? inst_hold_p1 : inst_i), valid: vld_p1};

    assign pc_o       = pc_p0;
    assign if_pc_o    = if_id_p1.pc;
    assign if_inst_o  = if_id_p1.inst;
    assign if_valid_o = if_id_p1.valid;
    assign addr_err_o = addr_err_q;

`ifdef FETCH_PERF_CNT_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    logic [31:0] fetch_cnt_q;
    logic [31:0] redirect_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_cnt_q    <= '0;
            redirect_cnt_q <= '0;
        end else begin
            if (advance && !flush_i) fetch_cnt_q <= sat_inc(fetch_cnt_q);
            if (redirect) redirect_cnt_q <= sat_inc(redirect_cnt_q);
        end
    end

    assign fetch_cnt_o    = fetch_cnt_q;
    assign redirect_cnt_o = redirect_cnt_q;
`endif

endmodule

// File: tb/tb_pc_fetch.sv
// Bench for pc_fetch: directed scenarios then randomized control traffic, checked against a
// behavioural model in which every valid IF/ID word must equal memory at its PC.
module tb_pc_fetch;

    localparam int DEPTH = 128;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_i, halt_i, stall_i, branch_taken_i, flush_i;
    logic [31:0] branch_target_i;
    logic [31:0] pc_o, inst_i, if_pc_o, if_inst_o;
    logic        if_valid_o, addr_err_o;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt_o, redirect_cnt_o;
`endif

    logic [31:0] mem [DEPTH];

    int n_vec = 0;
    int n_err = 0;

    int          m_state;
    logic [31:0] m_pc, m_ifpc, m_fc, m_rc;
    logic        m_valid, m_err;

    always #5 clk = ~clk;

    always @(posedge clk) inst_i <= mem[pc_o[6:0]];

    pc_fetch #(
        .IMEM_DEPTH(DEPTH),
        .RESET_PC  (32'd0)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start_i        (start_i),
        .halt_i         (halt_i),
        .stall_i        (stall_i),
        .branch_taken_i (branch_taken_i),
        .branch_target_i(branch_target_i),
        .flush_i        (flush_i),
        .pc_o           (pc_o),
        .inst_i         (inst_i),
        .if_pc_o        (if_pc_o),
        .if_inst_o      (if_inst_o),
        .if_valid_o     (if_valid_o),
        .addr_err_o     (addr_err_o)
`ifdef FETCH_PERF_CNT_EN
        ,
        .fetch_cnt_o    (fetch_cnt_o),
        .redirect_cnt_o (redirect_cnt_o)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = 0;
        m_pc    = 32'd0;
        m_ifpc  = 32'd0;
        m_valid = 1'b0;
        m_err   = 1'b0;
        m_fc    = 32'd0;
        m_rc    = 32'd0;
    endtask

    // One clock edge of fetch behaviour: 0=idle, 1=run, 2=halt.
    task automatic model_step();
        int nxt;
        nxt = m_state;
        if (m_state != 1) begin
            m_valid = 1'b0;
            if (start_i) nxt = 1;
        end else begin
            if (halt_i) nxt = 2;
            if (branch_taken_i) begin
                if (branch_target_i >= 32'(DEPTH)) m_err = 1'b1;
                m_pc    = branch_target_i % 32'(DEPTH);
                m_valid = 1'b0;
                m_rc    = m_rc + 32'd1;
            end else if (halt_i) begin
                m_valid = 1'b0;
            end else if (stall_i) begin
                if (flush_i) m_valid = 1'b0;
            end else begin
                m_ifpc  = m_pc;
                m_pc    = (m_pc + 32'd1) % 32'(DEPTH);
                m_valid = !flush_i;
                if (!flush_i) m_fc = m_fc + 32'd1;
            end
        end
        m_state = nxt;
    endtask

    task automatic check_outputs();
        chk("pc_o", pc_o, m_pc);
        chk("if_valid_o", 32'(if_valid_o), 32'(m_valid));
        chk("if_pc_o", if_pc_o, m_ifpc);
        chk("addr_err_o", 32'(addr_err_o), 32'(m_err));
        if (m_valid) chk("if_inst_o", if_inst_o, mem[m_ifpc[6:0]]);
`ifdef FETCH_PERF_CNT_EN
        chk("fetch_cnt_o", fetch_cnt_o, m_fc);
        chk("redirect_cnt_o", redirect_cnt_o, m_rc);
`endif
    endtask

    task automatic step(input bit st, input bit hl, input bit sl, input bit br,
                        input logic [31:0] tg, input bit fl);
        start_i         = st;
        halt_i          = hl;
        stall_i         = sl;
        branch_taken_i  = br;
        branch_target_i = tg;
        flush_i         = fl;
        @(posedge clk);
        model_step();
        #1;
        check_outputs();
    endtask

    task automatic adv();
        step(0, 0, 0, 0, 32'd0, 0);
    endtask

    task automatic do_reset();
        rst_n           = 1'b0;
        start_i         = 1'b0;
        halt_i          = 1'b0;
        stall_i         = 1'b0;
        branch_taken_i  = 1'b0;
        branch_target_i = 32'd0;
        flush_i         = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        check_outputs();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = 32'(i + 100);
        do_reset();

        // basic streaming from RESET_PC
        step(1, 0, 0, 0, 32'd0, 0);
        repeat (5) adv();
        chk("stream_if_pc", if_pc_o, 32'd4);
        // stall holding word at pc 4
        repeat (3) step(0, 0, 1, 0, 32'd0, 0);
        chk("stall_hold_inst", if_inst_o, 32'd104);
        repeat (2) adv();
        // redirect to 20
        step(0, 0, 0, 1, 32'd20, 0);
        repeat (3) adv();
        // wrap at top of memory
        for (int i = 0; i < 200 && pc_o != 32'd127; i++) adv();
        repeat (2) adv();
        // out-of-range redirect target
        step(0, 0, 0, 1, 32'd200, 0);
        chk("oob_target_pc", pc_o, 32'd72);
        repeat (2) adv();
        chk("addr_err_sticky", 32'(addr_err_o), 32'd1);
        // halt at pc 10 and resume
        for (int i = 0; i < 200 && pc_o != 32'd10; i++) adv();
        step(0, 1, 0, 0, 32'd0, 0);
        repeat (3) adv();
        step(1, 0, 0, 0, 32'd0, 0);
        repeat (3) adv();
        // flush on advance and on stall
        step(0, 0, 0, 0, 32'd0, 1);
        adv();
        step(0, 0, 1, 0, 32'd0, 0);
        step(0, 0, 1, 0, 32'd0, 1);
        repeat (2) adv();
        // async reset in the middle of a stall with the hold flag set
        repeat (2) step(0, 0, 1, 0, 32'd0, 0);
        #1;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs();
        chk("async_rst_err", 32'(addr_err_o), 32'd0);
        @(negedge clk);
        rst_n   = 1'b1;
        stall_i = 1'b0;
        step(1, 0, 0, 0, 32'd0, 0);
        repeat (3) adv();

        // randomized control traffic over random memory contents
        for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if (i % 1000 == 999) begin
                do_reset();
            end else begin
                step($urandom_range(99, 0) < 10,
                     $urandom_range(99, 0) < 4,
                     $urandom_range(99, 0) < 25,
                     $urandom_range(99, 0) < 8,
                     32'($urandom_range(255, 0)),
                     $urandom_range(99, 0) < 6);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
